// File: rtl/collector_pkg.sv
// Shared definitions for fan-in collector blocks: default sizes, source index type
// and the round-robin search used by every fan-in arbiter.
package collector_pkg;

    localparam int unsigned N_CHILD_DEFAULT = 5;
    localparam int unsigned DW_DEFAULT      = 32;
    localparam int unsigned SRC_W_DEFAULT   = $clog2(N_CHILD_DEFAULT);
    // Widest fan-in the shared search supports.
    localparam int unsigned RR_MAX          = 16;

    typedef logic [SRC_W_DEFAULT-1:0] src_idx_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First requester at or after ptr, wrapping at n. Walking the offsets from
    // the far end down lets the nearest requester overwrite earlier picks.
    function automatic rr_pick_t rr_next(input logic [3:0]  ptr,
                                         input logic [15:0] req,
                                         input int unsigned n);
        rr_pick_t    pick;
        int unsigned cand;
        pick = '0;
        for (int i = int'(RR_MAX) - 1; i >= 0; i--) begin
            if (i < int'(n)) begin
                cand = (32'(ptr) + 32'(i)) % n;
                if (req[cand[3:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = cand[3:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters starting the search at an externally owned
// pointer. Purely combinational; grant is one-hot or zero.
module rr_arbiter
    import collector_pkg::*;
#(
    parameter int unsigned N = 5,
    localparam int unsigned SRC_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SRC_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [SRC_W-1:0] o_grant_idx,
    output logic             o_any
);

    logic [15:0] w_req_ext;
    logic [3:0]  w_ptr_ext;
    rr_pick_t    w_pick;
    logic        w_unused_idx;

    // Widen to the shared search width and pick the next requester.
    always_comb begin
        w_req_ext          = '0;
        w_req_ext[N-1:0]   = i_req;
        w_ptr_ext          = '0;
        w_ptr_ext[SRC_W-1:0] = i_ptr;
        w_pick             = rr_next(w_ptr_ext, w_req_ext, N);
        o_any              = w_pick.found;
        o_grant_idx        = w_pick.idx[SRC_W-1:0];
        o_grant            = '0;
        if (w_pick.found) begin
            o_grant = {{(N-1){1'b0}}, 1'b1} << w_pick.idx;
        end
    end

    // Upper index bits are always zero for N below 16.
    assign w_unused_idx = ^w_pick.idx;

endmodule

// File: rtl/child_response_collector.sv
// N-way fan-in of child response streams into one upstream stream with a
// one-entry output register, round-robin arbitration and sticky done tracking.
module child_response_collector
    import collector_pkg::*;
#(
    parameter int unsigned N_CHILD = N_CHILD_DEFAULT,
    parameter int unsigned DW      = DW_DEFAULT,
    localparam int unsigned SRC_W  = $clog2(N_CHILD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CHILD-1:0]    child_valid,
    output logic [N_CHILD-1:0]    child_ready,
    input  logic [N_CHILD*DW-1:0] child_data,
    input  logic [N_CHILD-1:0]    child_last,
    output logic                  up_valid,
    input  logic                  up_ready,
    output logic [DW-1:0]         up_data,
    output logic [SRC_W-1:0]      up_src,
    output logic                  up_last,
    input  logic                  clear,
    output logic [N_CHILD-1:0]    done_mask,
    output logic                  all_done
);

    logic [SRC_W-1:0]   r_ptr;
    logic               r_up_valid;
    logic [DW-1:0]      r_up_data;
    logic [SRC_W-1:0]   r_up_src;
    logic               r_up_last;
    logic [N_CHILD-1:0] r_done_mask;
    logic               r_all_done;

    logic [N_CHILD-1:0] w_grant;
    logic [SRC_W-1:0]   w_grant_idx;
    logic               w_any;
    logic               w_can_load;
    logic               w_xfer;
    logic [DW-1:0]      w_sel_data;
    logic               w_sel_last;
    logic [N_CHILD-1:0] w_done_set;
    logic [N_CHILD-1:0] w_done_d;
    logic [SRC_W-1:0]   w_ptr_d;

    // Grant never looks at up_ready; backpressure only gates child_ready.
    rr_arbiter #(
        .N (N_CHILD)
    ) u_arb (
        .i_req       (child_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // Handshake, data select, pointer advance and done-mask next state.
    always_comb begin
        w_can_load  = !r_up_valid || up_ready;
        w_xfer      = w_any && w_can_load && !rst;
        child_ready = rst ? '0 : (w_grant & {N_CHILD{w_can_load}});
        w_sel_data  = child_data[w_grant_idx*DW +: DW];
        w_sel_last  = child_last[w_grant_idx];
        w_done_set  = (w_xfer && w_sel_last) ? w_grant : '0;
        // clear drops history but never a last beat landing this cycle.
        w_done_d    = (clear ? '0 : r_done_mask) | w_done_set;
        w_ptr_d     = r_ptr;
        if (w_xfer) begin
            w_ptr_d = (w_grant_idx == SRC_W'(N_CHILD - 1)) ? '0 : w_grant_idx + SRC_W'(1);
        end
    end

    // Output register: loads on transfer, empties when drained with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up_valid <= 1'b0;
            r_up_data  <= '0;
            r_up_src   <= '0;
            r_up_last  <= 1'b0;
            r_ptr      <= '0;
        end else begin
            r_ptr <= w_ptr_d;
            if (w_xfer) begin
                r_up_valid <= 1'b1;
                r_up_data  <= w_sel_data;
                r_up_src   <= w_grant_idx;
                r_up_last  <= w_sel_last;
            end else if (up_ready) begin
                r_up_valid <= 1'b0;
            end
        end
    end

    // Sticky done tracking; all_done tracks the next mask so both rise together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_mask <= '0;
            r_all_done  <= 1'b0;
        end else begin
            r_done_mask <= w_done_d;
            r_all_done  <= &w_done_d;
        end
    end

    assign up_valid  = r_up_valid;
    assign up_data   = r_up_data;
    assign up_src    = r_up_src;
    assign up_last   = r_up_last;
    assign done_mask = r_done_mask;
    assign all_done  = r_all_done;

endmodule

// File: tb/tb_child_response_collector.sv
// Directed bench for child_response_collector with hand-computed expectations.
module tb_child_response_collector;

    localparam int N  = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    child_valid;
    logic [N-1:0]    child_ready;
    logic [N*DW-1:0] child_data;
    logic [N-1:0]    child_last;
    logic            up_valid;
    logic            up_ready;
    logic [DW-1:0]   up_data;
    logic [2:0]      up_src;
    logic            up_last;
    logic            clear;
    logic [N-1:0]    done_mask;
    logic            all_done;

    int n_tests = 0;
    int n_fail  = 0;

    child_response_collector #(
        .N_CHILD (N),
        .DW      (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .child_valid (child_valid),
        .child_ready (child_ready),
        .child_data  (child_data),
        .child_last  (child_last),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_data     (up_data),
        .up_src      (up_src),
        .up_last     (up_last),
        .clear       (clear),
        .done_mask   (done_mask),
        .all_done    (all_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < N; i++) child_data[i*DW +: DW] = base + 32'(i);
    endtask

    logic [2:0] order [5] = '{3'd4, 3'd0, 3'd3, 3'd1, 3'd2};
    logic [4:0] masks [5] = '{5'h10, 5'h11, 5'h19, 5'h1B, 5'h1F};

    initial begin
        rst         = 1'b1;
        child_valid = 5'h1F;
        child_last  = '0;
        child_data  = '0;
        set_data(32'h100);
        up_ready    = 1'b1;
        clear       = 1'b0;

        // Power-on reset with requests pending
        #12;
        check("rst_up_valid", up_valid, 0);
        check("rst_up_data", up_data, 0);
        check("rst_up_src", up_src, 0);
        check("rst_done", done_mask, 0);
        check("rst_all_done", all_done, 0);
        check("rst_child_ready", child_ready, 0);

        @(posedge clk);
        #1;
        rst         = 1'b0;
        child_valid = '0;

        // Single child 2: A, B, C(last)
        child_valid = 5'b00100;
        child_data[2*DW +: DW] = 32'hA;
        #1;
        check("single_ready", child_ready, 5'b00100);
        step();
        check("single_A_valid", up_valid, 1);
        check("single_A_data", up_data, 32'hA);
        check("single_A_src", up_src, 2);
        check("single_A_last", up_last, 0);
        child_data[2*DW +: DW] = 32'hB;
        step();
        check("single_B_data", up_data, 32'hB);
        child_data[2*DW +: DW] = 32'hC;
        child_last = 5'b00100;
        step();
        check("single_C_data", up_data, 32'hC);
        check("single_C_last", up_last, 1);
        check("single_done", done_mask, 5'b00100);
        check("single_all_done", all_done, 0);
        child_valid = '0;
        child_last  = '0;
        step();
        check("single_drain", up_valid, 0);

        // Move pointer from 3 to 0 via one beat from child 4
        child_valid = 5'b10000;
        step();
        check("prime_src", up_src, 4);

        // Fairness: all valid, expect 0,1,2,3,4,0,1
        child_valid = 5'h1F;
        set_data(32'h100);
        for (int k = 0; k < 7; k++) begin
            step();
            check("fair_src", up_src, 64'(k % 5));
            check("fair_data", up_data, 64'(32'h100 + k % 5));
        end

        // Backpressure for 4 cycles holding the src 1 beat
        up_ready = 1'b0;
        #1;
        check("bp_ready_low", child_ready, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("bp_valid", up_valid, 1);
            check("bp_src", up_src, 1);
            check("bp_data", up_data, 32'h101);
            check("bp_child_ready", child_ready, 0);
        end
        up_ready = 1'b1;
        #1;
        check("bp_release_ready", child_ready, 5'b00100);
        step();
        check("bp_no_bubble_valid", up_valid, 1);
        check("bp_no_bubble_src", up_src, 2);
        child_valid = '0;
        step();
        check("bp_drain", up_valid, 0);

        // Completion in order 4,0,3,1,2
        clear = 1'b1;
        step();
        check("clr_done", done_mask, 0);
        check("clr_all_done", all_done, 0);
        clear = 1'b0;
        for (int j = 0; j < 5; j++) begin
            child_valid = 5'b00001 << order[j];
            child_last  = 5'b00001 << order[j];
            step();
            check("comp_src", up_src, order[j]);
            check("comp_mask", done_mask, masks[j]);
            check("comp_all_done", all_done, (j == 4) ? 1 : 0);
        end

        // Clear racing with child 3's last beat, old mask 5'h1F
        clear       = 1'b1;
        child_valid = 5'b01000;
        child_last  = 5'b01000;
        step();
        check("race_mask", done_mask, 5'b01000);
        check("race_all_done", all_done, 0);
        clear       = 1'b0;
        child_valid = '0;
        child_last  = '0;
        step();

        // Reset mid-stream with a held upstream beat
        up_ready    = 1'b0;
        child_valid = 5'b00001;
        child_data[0 +: DW] = 32'hDEAD;
        step();
        check("mid_valid_pre", up_valid, 1);
        check("mid_data_pre", up_data, 32'hDEAD);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", up_valid, 0);
        check("mid_rst_data", up_data, 0);
        check("mid_rst_src", up_src, 0);
        check("mid_rst_done", done_mask, 0);
        check("mid_rst_ready", child_ready, 0);
        step();
        rst         = 1'b0;
        up_ready    = 1'b1;
        child_valid = 5'b00011;
        #1;
        check("post_rst_ptr0", child_ready, 5'b00001);
        child_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
